// File: rtl/prbs_chk_itu_o150.sv
// Self-synchronising PRBS9 checker (x^9 + x^5 + 1): locks onto the incoming word stream and counts bit errors.
// Optional build macro PRBS_CHK_INV_EN: check the inverted pattern instead of the true one.
module prbs_chk_itu_o150 #(
    parameter int DATW     = 64,
    parameter int STA0     = 9,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4,
    parameter int ERRW     = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      iclr,
    input  logic                      ivld,
    input  logic [DATW-1:0]           idat,
    output logic                      olock,
    output logic                      oerr_vld,
    output logic [$clog2(DATW+1)-1:0] oerr_bits,
    output logic [ERRW-1:0]           oerr_cnt
);

    localparam int NBW = $clog2(DATW + 1);
    localparam int TAP = 5;
    localparam int SW  = ((ERRW > NBW) ? ERRW : NBW) + 1;
    localparam logic [3:0]    LOCK_C  = 4'(LOCK_CNT);
    localparam logic [3:0]    LOSS_C  = 4'(LOSS_CNT);
    localparam logic [SW-1:0] CNT_MAX = (SW'(1) << ERRW) - SW'(1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [STA0-1:0]     ref_q, ref_d;
    logic [3:0]          match_q, match_d;
    logic [3:0]          miss_q, miss_d;
    logic                oerr_vld_q, oerr_vld_d;
    logic [NBW-1:0]      oerr_bits_q, oerr_bits_d;
    logic [ERRW-1:0]     oerr_cnt_q, oerr_cnt_d;

    logic [DATW-1:0]      data_c;
    logic [DATW+STA0-1:0] ext;
    logic [DATW-1:0]      exp_w;
    logic [NBW-1:0]       nerr;
    logic                 clean;
    logic [SW-1:0]        sum;
    logic [3:0]           match_inc;
    logic [3:0]           miss_inc;

`ifdef PRBS_CHK_INV_EN
    assign data_c = ~idat;
`else
    assign data_c = idat;
`endif

    function automatic logic [NBW-1:0] popcnt(input logic [DATW-1:0] v);
        logic [NBW-1:0] n;
        n = '0;
        for (int i = 0; i < DATW; i++) begin
            n = n + NBW'(v[i]);
        end
        return n;
    endfunction

    // Serial expansion of the reference: ext[STA0+i] is stream bit n+i, oldest state bit at ext[0].
    always_comb begin
        ext             = '0;
        ext[STA0-1:0]   = ref_q;
        for (int i = 0; i < DATW; i++) begin
            ext[STA0+i] = ext[i] ^ ext[i+STA0-TAP];
        end
    end

    assign exp_w     = ext[DATW+STA0-1:STA0];
    assign nerr      = popcnt(exp_w ^ data_c);
    assign clean     = (exp_w == data_c) && (data_c != '0);
    assign sum       = SW'(oerr_cnt_q) + SW'(nerr);
    assign match_inc = match_q + 4'd1;
    assign miss_inc  = miss_q + 4'd1;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        state_d     = state_q;
        ref_d       = ref_q;
        match_d     = match_q;
        miss_d      = miss_q;
        oerr_vld_d  = 1'b0;
        oerr_bits_d = oerr_bits_q;
        oerr_cnt_d  = oerr_cnt_q;

        if (ivld) begin
            if (state_q == SEARCH) begin
                ref_d = data_c[DATW-1:DATW-STA0];
                if (clean) begin
                    match_d = match_inc;
                    if (match_inc == LOCK_C) begin
                        state_d = LOCKED;
                        miss_d  = '0;
                    end
                end else begin
                    match_d = '0;
                end
            end else begin
                // Reference free-runs so received errors never leak into the prediction.
                ref_d       = exp_w[DATW-1:DATW-STA0];
                oerr_vld_d  = 1'b1;
                oerr_bits_d = nerr;
                oerr_cnt_d  = (sum > CNT_MAX) ? CNT_MAX[ERRW-1:0] : sum[ERRW-1:0];
                if (nerr != '0) begin
                    miss_d = miss_inc;
                    if (miss_inc == LOSS_C) begin
                        state_d = SEARCH;
                        match_d = '0;
                        miss_d  = '0;
                    end
                end else begin
                    miss_d = '0;
                end
            end
        end

        if (iclr) begin
            oerr_cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments; the comb block above uses blocking ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= SEARCH;
            ref_q       <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            oerr_vld_q  <= 1'b0;
            oerr_bits_q <= '0;
            oerr_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            oerr_vld_q  <= oerr_vld_d;
            oerr_bits_q <= oerr_bits_d;
            oerr_cnt_q  <= oerr_cnt_d;
        end
    end

    assign olock     = (state_q == LOCKED);
    assign oerr_vld  = oerr_vld_q;
    assign oerr_bits = oerr_bits_q;
    assign oerr_cnt  = oerr_cnt_q;

endmodule

// File: tb/tb_prbs_chk_itu_o150.sv
// Scoreboard bench for prbs_chk_itu_o150: two instances (ERRW=32 and ERRW=4) share one directed stimulus stream.
module tb_prbs_chk_itu_o150;

    logic        clk = 1'b0;
    logic        rstn;
    logic        iclr;
    logic        ivld;
    logic [63:0] idat;

    logic        lock32, vld32, lock4, vld4;
    logic [6:0]  bits32, bits4;
    logic [31:0] cnt32;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    prbs_chk_itu_o150 #(.DATW(64), .STA0(9), .LOCK_CNT(4), .LOSS_CNT(4), .ERRW(32)) dut32 (
        .clk(clk), .rstn(rstn), .iclr(iclr), .ivld(ivld), .idat(idat),
        .olock(lock32), .oerr_vld(vld32), .oerr_bits(bits32), .oerr_cnt(cnt32)
    );

    prbs_chk_itu_o150 #(.DATW(64), .STA0(9), .LOCK_CNT(4), .LOSS_CNT(4), .ERRW(4)) dut4 (
        .clk(clk), .rstn(rstn), .iclr(iclr), .ivld(ivld), .idat(idat),
        .olock(lock4), .oerr_vld(vld4), .oerr_bits(bits4), .oerr_cnt(cnt4)
    );

    typedef struct {
        bit pulse;
        int bits;
        bit lock;
        int acc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          mon_sat;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          acc;
    logic [8:0]  gen_s;
    logic [63:0] m1, m2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Serial O.150 generator: state bit 0 is d[n-9], bit 8 is d[n-1].
    task automatic gen_word(output logic [63:0] w);
        logic b;
        for (int i = 0; i < 64; i++) begin
            b     = gen_s[0] ^ gen_s[4];
            w[i]  = b;
            gen_s = {b, gen_s[8:1]};
        end
    endtask

    task automatic cyc(input bit v, input logic [63:0] d, input bit clr,
                       input bit pulse, input bit lock, input int nerr);
        @(negedge clk);
        ivld = v;
        idat = d;
        iclr = clr;
        if (clr) acc = 0;
        else if (pulse) acc = acc + nerr;
        sbq.push_back('{pulse, nerr, lock, acc});
    endtask

    task automatic word(input logic [63:0] mask, input bit clr, input bit pulse, input bit lock);
        logic [63:0] w;
        gen_word(w);
        cyc(1'b1, w ^ mask, clr, pulse, lock, $countones(mask));
    endtask

    task automatic idle(input int n, input bit lock);
        for (int i = 0; i < n; i++) cyc(1'b0, 64'h0, 1'b0, 1'b0, lock, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " lock32"}, 64'(lock32), 64'h0);
        check({tag, " vld32"},  64'(vld32),  64'h0);
        check({tag, " bits32"}, 64'(bits32), 64'h0);
        check({tag, " cnt32"},  64'(cnt32),  64'h0);
        check({tag, " lock4"},  64'(lock4),  64'h0);
        check({tag, " vld4"},   64'(vld4),   64'h0);
        check({tag, " bits4"},  64'(bits4),  64'h0);
        check({tag, " cnt4"},   64'(cnt4),   64'h0);
    endtask

    // Monitor: each cycle's expectation is popped after the edge that registered that cycle's input.
    always @(posedge clk) begin
        #2;
        if (sbq.size() != 0) begin
            mon_e   = sbq.pop_front();
            mon_sat = (mon_e.acc > 15) ? 15 : mon_e.acc;
            check("olock32",    64'(lock32), 64'(mon_e.lock));
            check("olock4",     64'(lock4),  64'(mon_e.lock));
            check("oerr_vld32", 64'(vld32),  64'(mon_e.pulse));
            check("oerr_vld4",  64'(vld4),   64'(mon_e.pulse));
            check("oerr_cnt32", 64'(cnt32),  64'(mon_e.acc));
            check("oerr_cnt4",  64'(cnt4),   64'(mon_sat));
            if (mon_e.pulse) begin
                check("oerr_bits32", 64'(bits32), 64'(mon_e.bits));
                check("oerr_bits4",  64'(bits4),  64'(mon_e.bits));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rstn  = 1'b1;
        ivld  = 1'b0;
        iclr  = 1'b0;
        idat  = '0;
        acc   = 0;
        gen_s = 9'h1FF;
        m1    = 64'h0000_0000_0000_0008;
        m2    = 64'h0000_0000_0000_0401;
        #1 rstn = 1'b0;
        #1 check_zero("reset");
        idle(2, 1'b0);
        rstn = 1'b1;

        // Clean stream: the first word only seeds the reference, the next four clean words lock.
        word(64'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) word(64'h0, 1'b0, 1'b0, 1'b0);
        word(64'h0, 1'b0, 1'b0, 1'b1);
        repeat (3) word(64'h0, 1'b0, 1'b1, 1'b1);

        // Single flipped bit, then a clean word with no error carried over.
        word(m1, 1'b0, 1'b1, 1'b1);
        word(64'h0, 1'b0, 1'b1, 1'b1);
        word(64'h0, 1'b1, 1'b1, 1'b1);

        // Four 2-bit-error words drop lock; the free-running reference relocks on four clean words.
        repeat (3) word(m2, 1'b0, 1'b1, 1'b1);
        word(m2, 1'b0, 1'b1, 1'b0);
        repeat (3) word(64'h0, 1'b0, 1'b0, 1'b0);
        word(64'h0, 1'b0, 1'b0, 1'b1);
        word(64'h0, 1'b1, 1'b1, 1'b1);

        // Twenty spread single-bit errors: 32-bit count reaches 20, 4-bit count holds at 15.
        for (int i = 0; i < 20; i++) begin
            word(64'h1 << (i * 3), 1'b0, 1'b1, 1'b1);
            word(64'h0, 1'b0, 1'b1, 1'b1);
        end

        // Asynchronous reset between edges clears every output at once.
        @(posedge clk);
        #3 rstn = 1'b0;
        acc = 0;
        #1 check_zero("midreset");
        idle(2, 1'b0);
        rstn = 1'b1;

        // All-zero words never count as clean.
        repeat (50) cyc(1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 0);

        // Gapped stream: lock on the fifth valid word, no pulses in idle cycles.
        for (int k = 0; k < 5; k++) begin
            word(64'h0, 1'b0, 1'b0, k == 4);
            idle(1, k == 4);
        end
        repeat (2) begin
            word(64'h0, 1'b0, 1'b1, 1'b1);
            idle(1, 1'b1);
        end
        word(m1, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b1);
        word(m1, 1'b1, 1'b1, 1'b1);
        idle(1, 1'b1);
        word(64'h0, 1'b0, 1'b1, 1'b1);

        repeat (3) @(posedge clk);
        #4;
        check("scoreboard drained", 64'(sbq.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
